// File: rtl/branch_predict_unit.sv
// Branch prediction unit: direct-mapped BTB with 2-bit saturating counters,
// registered IF/ID prediction, and saturating resolved/mispredict statistics.
module branch_predict_unit #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc,
  input  logic        IF_ID_Freeze,
  input  logic        Flush,
  input  logic        Invalidate_All,
  input  logic        Update_Valid__EX_MEM,
  input  logic [31:0] Update_PC__EX_MEM,
  input  logic        Branch_Taken__EX_MEM,
  input  logic [31:0] Branch_Target_Addr__EX_MEM,
  input  logic        Pred_Taken__EX_MEM,
  output logic        BPU__Branch_Taken__IF_ID,
  output logic [31:0] BPU__Branch_Target_Addr__IF_ID,
  output logic [15:0] Branch_Count,
  output logic [15:0] Mispredict_Count
);

  localparam int unsigned IDX     = $clog2(ENTRIES);
  localparam int unsigned TAG_W   = 32 - IDX - 2;
  localparam int unsigned CNT_W   = 16;
  localparam logic [1:0]  CTR_RST = 2'b01;
  localparam logic [1:0]  CTR_NEW = 2'b10;
  localparam logic [1:0]  CTR_MAX = 2'b11;
  localparam logic [1:0]  CTR_MIN = 2'b00;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  // Instruction-word alignment bits never take part in indexing or tagging.
  logic unused_align_bits;
  assign unused_align_bits = ^{pc[1:0], Update_PC__EX_MEM[1:0]};

  // Fetch-side lookup against the table as it stands before this edge
  logic [IDX-1:0]   l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit;
  logic             l_taken;
  logic [31:0]      l_next;

  always_comb begin
    l_idx   = pc[IDX+1:2];
    l_tag   = pc[31:IDX+2];
    l_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    l_taken = l_hit && ctr_q[l_idx][1];
    l_next  = l_taken ? tgt_q[l_idx] : (pc + 32'd4);
  end

  // Resolve-side decode: hit test, counter step and mispredict classification
  logic [IDX-1:0]   u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [1:0]       u_ctr_nxt;
  logic             u_train;
  logic             u_alloc;
  logic             u_wr_tgt;
  logic             u_mispredict;

  always_comb begin
    u_idx        = Update_PC__EX_MEM[IDX+1:2];
    u_tag        = Update_PC__EX_MEM[31:IDX+2];
    u_hit        = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_ctr_nxt    = ctr_q[u_idx];
    u_train      = 1'b0;
    u_alloc      = 1'b0;
    u_wr_tgt     = 1'b0;
    u_mispredict = 1'b0;

    if (Branch_Taken__EX_MEM) begin
      if (ctr_q[u_idx] != CTR_MAX) u_ctr_nxt = ctr_q[u_idx] + 2'd1;
    end else begin
      if (ctr_q[u_idx] != CTR_MIN) u_ctr_nxt = ctr_q[u_idx] - 2'd1;
    end

    if (Update_Valid__EX_MEM && !Invalidate_All) begin
      u_train  = u_hit;
      u_alloc  = !u_hit && Branch_Taken__EX_MEM;
      u_wr_tgt = Branch_Taken__EX_MEM;
    end

    if (Update_Valid__EX_MEM) begin
      if (Pred_Taken__EX_MEM != Branch_Taken__EX_MEM) begin
        u_mispredict = 1'b1;
      end else if (Pred_Taken__EX_MEM &&
                   (!u_hit || (tgt_q[u_idx] != Branch_Target_Addr__EX_MEM))) begin
        u_mispredict = 1'b1;
      end
    end
  end

  // Valid bits and counters; invalidate wins over any same-cycle training
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_RST;
      end
    end else if (Invalidate_All) begin
      valid_q <= '0;
    end else if (u_train) begin
      ctr_q[u_idx] <= u_ctr_nxt;
    end else if (u_alloc) begin
      valid_q[u_idx] <= 1'b1;
      ctr_q[u_idx]   <= CTR_NEW;
    end
  end

  // Tags and targets are qualified by valid bits, so they carry no reset
  always_ff @(posedge CLK) begin
    if (u_wr_tgt) begin
      tgt_q[u_idx] <= Branch_Target_Addr__EX_MEM;
    end
    if (u_alloc) begin
      tag_q[u_idx] <= u_tag;
    end
  end

  // IF/ID prediction register: flush beats freeze
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      BPU__Branch_Taken__IF_ID       <= 1'b0;
      BPU__Branch_Target_Addr__IF_ID <= '0;
    end else if (Flush) begin
      BPU__Branch_Taken__IF_ID       <= 1'b0;
      BPU__Branch_Target_Addr__IF_ID <= '0;
    end else if (!IF_ID_Freeze) begin
      BPU__Branch_Taken__IF_ID       <= l_taken;
      BPU__Branch_Target_Addr__IF_ID <= l_next;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Branch_Count     <= '0;
      Mispredict_Count <= '0;
    end else begin
      if (Update_Valid__EX_MEM && (Branch_Count != CNT_MAX)) begin
        Branch_Count <= Branch_Count + CNT_W'(1);
      end
      if (u_mispredict && (Mispredict_Count != CNT_MAX)) begin
        Mispredict_Count <= Mispredict_Count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter: ENTRIES, 16, BTB entry count (power of two, 4..64); IDX = log2(ENTRIES).
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: pc  input  32  current fetch PC used for lookup.
REQ-005 SHALL have port: IF_ID_Freeze  input  1  holds registered prediction outputs.
REQ-006 SHALL have port: Flush  input  1  clears registered prediction (MEM_WB redirect / IRQ).
REQ-007 SHALL have port: Invalidate_All  input  1  clears every BTB valid bit.
REQ-008 SHALL have port: Update_Valid__EX_MEM  input  1  resolved branch present in EX_MEM.
REQ-009 SHALL have port: Update_PC__EX_MEM  input  32  PC of resolved branch.
REQ-010 SHALL have port: Branch_Taken__EX_MEM  input  1  resolved direction.
REQ-011 SHALL have port: Branch_Target_Addr__EX_MEM  input  32  resolved target.
REQ-012 SHALL have port: Pred_Taken__EX_MEM  input  1  prediction originally issued for that branch.
REQ-013 SHALL have port: BPU__Branch_Taken__IF_ID  output  1  registered predict-taken.
REQ-014 SHALL have port: BPU__Branch_Target_Addr__IF_ID  output  32  registered predicted next PC.
REQ-015 SHALL have port: Branch_Count  output  16  resolved-branch counter.
REQ-016 SHALL have port: Mispredict_Count  output  16  mispredict counter.

Function
REQ-017 SHALL hold per entry: valid (1), tag (32-IDX-2), target (32), 2-bit saturating counter ctr.
REQ-018 SHALL index with pc[IDX+1:2] and tag-compare pc[31:IDX+2]; hit = valid & tag equal.
REQ-019 SHALL compute lookup combinationally from pre-edge table state; no update-to-lookup bypass in the same cycle.
REQ-020 SHALL, on each edge with Flush=0 and IF_ID_Freeze=0, register taken = hit & ctr[1]; target = entry target if taken, else pc+4 (32-bit wrap).
REQ-021 SHALL hold both outputs unchanged while IF_ID_Freeze=1 and Flush=0.
REQ-022 SHALL clear taken to 0 and target to 0 on an edge with Flush=1, regardless of IF_ID_Freeze.
REQ-023 SHALL, on Update_Valid__EX_MEM=1 with update hit, increment ctr (saturate 11) if taken else decrement (saturate 00), and overwrite target only if taken.
REQ-024 SHALL, on update miss with taken=1, allocate/replace the indexed entry: valid=1, tag, target, ctr=10.
REQ-025 SHALL not modify the table on update miss with taken=0.
REQ-026 SHALL give Invalidate_All priority over any same-cycle update: all valid=0, no allocation that cycle.
REQ-027 SHALL increment Branch_Count on every Update_Valid__EX_MEM=1 cycle, saturating at 0xFFFF.
REQ-028 SHALL increment Mispredict_Count when Update_Valid__EX_MEM=1 and (Pred_Taken__EX_MEM != Branch_Taken__EX_MEM) or (both 1 and prior entry target != resolved target or entry missed), saturating at 0xFFFF.
REQ-029 SHALL ignore all update inputs when Update_Valid__EX_MEM=0.

Reset
REQ-030 SHALL, while RST=0, immediately force all valid=0, ctr=01, BPU__Branch_Taken__IF_ID=0, BPU__Branch_Target_Addr__IF_ID=0, both counters=0.
REQ-031 SHALL discard any in-flight update asserted in the reset cycle; table targets/tags need no reset.
REQ-032 SHALL resume lookup on the first rising edge after RST deasserts.

Verification
REQ-033 SHALL cover: reset mid-run, release, pc=0x100 -> taken=0, target=0x104, counts 0.
REQ-034 SHALL cover: update PC=0x40 taken target=0x200 Pred=0, then pc=0x40 -> taken=1, target=0x200, Branch_Count=1, Mispredict_Count=1.
REQ-035 SHALL cover: one not-taken update of 0x40 (ctr 10->01) -> pc=0x40 yields taken=0, target=0x44; two taken updates -> ctr=11, taken=1.
REQ-036 SHALL cover: aliasing pc=0x80 (same index 0, different tag) after 0x40 allocated -> taken=0, target=0x84.
REQ-037 SHALL cover: IF_ID_Freeze=1 for 3 cycles with changing pc -> outputs held; Flush=1 with Freeze=1 -> outputs 0 next edge.
REQ-038 SHALL cover: Invalidate_All with simultaneous taken update of 0x40 -> pc=0x40 next yields taken=0; Branch_Count still increments; 65536+ updates -> counter stays 0xFFFF.
